pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. Merges per-operand load-use hazard flags from the two operand forwarders, branch redirects from EX, data-memory handshake waits and multi-cycle divider occupancy. Drives per-stage pipeline-register enables, bubble/flush strobes, a data-memory timeout pulse and a stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max MEM_WAIT cycles before abort (≥2)

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  reset, synchronous, active-low
- lu_hazard_rs1_i  in  1  load-use hazard, rs1 forwarder
- lu_hazard_rs2_i  in  1  load-use hazard, rs2 forwarder
- branch_taken_i  in  1  EX redirect, valid instruction
- dmem_req_i  in  1  MEM stage holds valid load/store request
- dmem_ack_i  in  1  data memory completes the request this cycle
- div_start_i  in  1  EX holds valid divide op
- div_done_i  in  1  divider result valid; level, held until EX advances
- stall_clr_i  in  1  clear stall counter
- if_en_o, id_en_o, ex_en_o, mem_en_o  out  1 each  IF/ID, ID/EX, EX/MEM, MEM/WB register enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  clear valid of that register
- id_ex_bubble_o, ex_mem_bubble_o  out  1 each  load NOP into that register
- dmem_timeout_o  out  1  one-cycle abort pulse
- stall_cycles_o  out  32  saturating stall counter

## Operation
- States: RUN, MEM_WAIT, DIV_WAIT. Flag div_pend (1 bit). Timeout counter tcnt, width $clog2(MEM_TIMEOUT+1).
- All outputs combinational from state + inputs (same cycle). Default: all enables 1, all flush/bubble 0.
- mem_stall = dmem_req_i && !dmem_ack_i. Priority in RUN: mem_stall > branch > divide > load-use.
- RUN, mem_stall: all enables 0; → MEM_WAIT, tcnt←1.
- RUN, branch_taken_i: if_id_flush_o=id_ex_flush_o=1, enables 1; load-use ignored.
- RUN, div_start_i && !div_done_i: if_en/id_en/ex_en=0, mem_en=1, ex_mem_bubble_o=1; → DIV_WAIT.
- RUN, lu_hazard_rs1_i || lu_hazard_rs2_i: if_en=id_en=0, id_ex_bubble_o=1, ex_en=mem_en=1. Exactly one cycle; load then forwards from MEM.
- MEM_WAIT: all enables 0. dmem_ack_i → enables 1 this cycle; next state DIV_WAIT if div_pend else RUN; div_pend←0. No ack and tcnt==MEM_TIMEOUT-1 → dmem_timeout_o=1, all three flushes=1, enables 1, → RUN, div_pend←0. Otherwise tcnt++.
- DIV_WAIT: same as RUN's divide case. mem_stall has priority: all enables 0, div_pend←1, → MEM_WAIT. div_done_i (no mem_stall) → enables 1, no bubble, → RUN.
- Stall counter: +1 each cycle if_en_o==0 while rstn_i high; saturates at 32'hFFFF_FFFF; stall_clr_i → 0 (clear wins over increment).

## Timing
- Reset (rstn_i low at edge): state RUN, tcnt 0, div_pend 0, counter 0. While rstn_i low: all enables 0, all flushes 1, bubbles 0, dmem_timeout_o 0.
- Zero-latency control: decision and stage effect occur at the same edge.
- Load-use: exactly 1 bubble per hazard. Memory ack in request cycle: 0 stall cycles. Ack after N wait cycles: N freeze cycles.
- Timeout fires in the (MEM_TIMEOUT-1)th MEM_WAIT cycle, i.e. MEM_TIMEOUT stalled cycles incl. entry.
- Branch during mem_stall: held (EX frozen), acted on first unfrozen RUN cycle.
- Reset mid-MEM_WAIT or DIV_WAIT: next cycle RUN, all flags cleared.

## Structure
- Package pipeline_ctrl_pkg: enum ctrl_state_e {RUN, MEM_WAIT, DIV_WAIT}; default MEM_TIMEOUT constant.
- Sub-module sat_counter (32-bit, inc/clr, saturating) for stall_cycles_o.

## Test plan
- lu_hazard_rs2_i=1 one cycle in RUN → if_en=id_en=0, id_ex_bubble=1 that cycle only; counter 0→1.
- dmem_req_i=1, ack at 4th cycle → 3 MEM_WAIT cycles plus entry with all enables 0; counter +4; RUN after ack.
- dmem_req_i held, no ack, MEM_TIMEOUT=16 → dmem_timeout_o pulse on 16th stalled cycle with all flushes 1; then RUN.
- div_start_i, mem_stall in DIV_WAIT, ack, div_done 2 cycles later → DIV_WAIT→MEM_WAIT→DIV_WAIT→RUN; ex_mem_bubble only in DIV_WAIT cycles.
- branch_taken_i with lu_hazard_rs1_i same cycle → both flushes 1, no bubble, enables 1.
- counter preloaded near max: saturates at 32'hFFFF_FFFF; stall_clr_i with stall → 0; rstn_i low in MEM_WAIT → RUN, counter 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // RUN: normal flow; MEM_WAIT: frozen on data memory; DIV_WAIT: EX held on divider.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } ctrl_state_e;

  // Default number of stalled cycles before a data-memory request is aborted.
  localparam int DEFAULT_MEM_TIMEOUT = 16;

  // Width of the stall-cycle performance counter.
  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q;

  // Clear beats increment; the value parks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: merges load-use hazards,
// branch redirects, data-memory waits and divider occupancy into per-stage
// register enables, flush/bubble strobes, a timeout pulse and a stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        lu_hazard_rs1_i,
  input  logic        lu_hazard_rs2_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        stall_clr_i,
  output logic        if_en_o,
  output logic        id_en_o,
  output logic        ex_en_o,
  output logic        mem_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_bubble_o,
  output logic        dmem_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam int                TCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state;
  ctrl_state_e       state_next;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_next;
  logic              div_pend;
  logic              div_pend_next;
  logic              mem_stall;
  logic              lu_hazard;
  logic              div_busy;

  assign mem_stall = dmem_req_i && !dmem_ack_i;
  assign lu_hazard = lu_hazard_rs1_i || lu_hazard_rs2_i;
  assign div_busy  = div_start_i && !div_done_i;

  // State, memory-wait timer and the "divide still owed after memory" flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= RUN;
      tcnt     <= '0;
      div_pend <= 1'b0;
    end else begin
      state    <= state_next;
      tcnt     <= tcnt_next;
      div_pend <= div_pend_next;
    end
  end

  // Same-cycle control decisions: outputs and next state from state plus inputs.
  always_comb begin
    if_en_o         = 1'b1;
    id_en_o         = 1'b1;
    ex_en_o         = 1'b1;
    mem_en_o        = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_flush_o  = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    dmem_timeout_o  = 1'b0;
    state_next      = state;
    tcnt_next       = tcnt;
    div_pend_next   = div_pend;

    if (!rstn_i) begin
      if_en_o        = 1'b0;
      id_en_o        = 1'b0;
      ex_en_o        = 1'b0;
      mem_en_o       = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      state_next     = RUN;
      tcnt_next      = '0;
      div_pend_next  = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            // Whole pipe freezes; a branch in EX stays put and is taken later.
            if_en_o    = 1'b0;
            id_en_o    = 1'b0;
            ex_en_o    = 1'b0;
            mem_en_o   = 1'b0;
            state_next = MEM_WAIT;
            tcnt_next  = TCNT_ONE;
          end else if (branch_taken_i) begin
            // Wrong-path instructions in IF/ID and ID/EX die; load-use is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (div_busy) begin
            if_en_o         = 1'b0;
            id_en_o         = 1'b0;
            ex_en_o         = 1'b0;
            ex_mem_bubble_o = 1'b1;
            state_next      = DIV_WAIT;
          end else if (lu_hazard) begin
            // One bubble is enough: the load reaches MEM and forwards from there.
            if_en_o        = 1'b0;
            id_en_o        = 1'b0;
            id_ex_bubble_o = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (dmem_ack_i) begin
            state_next    = div_pend ? DIV_WAIT : RUN;
            div_pend_next = 1'b0;
            tcnt_next     = '0;
          end else if (tcnt == TCNT_LAST) begin
            // Abort the access and drop everything younger than MEM.
            dmem_timeout_o = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            state_next     = RUN;
            div_pend_next  = 1'b0;
            tcnt_next      = '0;
          end else begin
            if_en_o   = 1'b0;
            id_en_o   = 1'b0;
            ex_en_o   = 1'b0;
            mem_en_o  = 1'b0;
            tcnt_next = tcnt + TCNT_ONE;
          end
        end

        DIV_WAIT: begin
          if (mem_stall) begin
            // Remember the divide so it resumes once memory answers.
            if_en_o       = 1'b0;
            id_en_o       = 1'b0;
            ex_en_o       = 1'b0;
            mem_en_o      = 1'b0;
            div_pend_next = 1'b1;
            state_next    = MEM_WAIT;
            tcnt_next     = TCNT_ONE;
          end else if (div_done_i) begin
            state_next = RUN;
          end else begin
            if_en_o         = 1'b0;
            id_en_o         = 1'b0;
            ex_en_o         = 1'b0;
            ex_mem_bubble_o = 1'b1;
          end
        end

        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .inc   (!if_en_o),
    .clr   (stall_clr_i),
    .count (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the sequencer.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 16;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;
  localparam int SMALL_MAX = 7;

  localparam int M_RUN = 0;
  localparam int M_MEM = 1;
  localparam int M_DIV = 2;

  logic clk = 1'b0;
  logic rstn_i, lu_hazard_rs1_i, lu_hazard_rs2_i, branch_taken_i;
  logic dmem_req_i, dmem_ack_i, div_start_i, div_done_i, stall_clr_i;
  logic if_en_o, id_en_o, ex_en_o, mem_en_o;
  logic if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
  logic id_ex_bubble_o, ex_mem_bubble_o, dmem_timeout_o;
  logic [31:0] stall_cycles_o;

  logic small_rstn, small_inc, small_clr;
  logic [2:0] small_count;

  int num_checks = 0;
  int num_fail = 0;

  int     m_mode = M_RUN;
  int     m_waited = 0;
  bit     m_div_pend = 1'b0;
  longint m_cnt = 0;
  int     m_small = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .lu_hazard_rs1_i (lu_hazard_rs1_i),
    .lu_hazard_rs2_i (lu_hazard_rs2_i),
    .branch_taken_i  (branch_taken_i),
    .dmem_req_i      (dmem_req_i),
    .dmem_ack_i      (dmem_ack_i),
    .div_start_i     (div_start_i),
    .div_done_i      (div_done_i),
    .stall_clr_i     (stall_clr_i),
    .if_en_o         (if_en_o),
    .id_en_o         (id_en_o),
    .ex_en_o         (ex_en_o),
    .mem_en_o        (mem_en_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .ex_mem_flush_o  (ex_mem_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .ex_mem_bubble_o (ex_mem_bubble_o),
    .dmem_timeout_o  (dmem_timeout_o),
    .stall_cycles_o  (stall_cycles_o)
  );

  sat_counter #(
    .WIDTH(3)
  ) u_small (
    .clk   (clk),
    .rstn  (small_rstn),
    .inc   (small_inc),
    .clr   (small_clr),
    .count (small_count)
  );

  // Count one comparison and report it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model mid-cycle, advance the model.
  task automatic applyStimulus(input string tag, input logic rstn, input logic lu1,
                               input logic lu2, input logic br, input logic req,
                               input logic ack, input logic ds, input logic dd,
                               input logic clr);
    logic [3:0] en;
    logic [2:0] fl;
    logic [1:0] bu;
    logic       to;
    logic       stall;
    logic [9:0] exp_vec;
    logic [9:0] obs_vec;

    rstn_i = rstn; lu_hazard_rs1_i = lu1; lu_hazard_rs2_i = lu2;
    branch_taken_i = br; dmem_req_i = req; dmem_ack_i = ack;
    div_start_i = ds; div_done_i = dd; stall_clr_i = clr;

    @(negedge clk);

    en = 4'b1111; fl = 3'b000; bu = 2'b00; to = 1'b0;
    stall = req && !ack;
    if (!rstn) begin
      en = 4'b0000; fl = 3'b111;
    end else if (m_mode == M_RUN) begin
      if (stall) en = 4'b0000;
      else if (br) fl = 3'b110;
      else if (ds && !dd) begin en = 4'b0001; bu = 2'b01; end
      else if (lu1 || lu2) begin en = 4'b0011; bu = 2'b10; end
    end else if (m_mode == M_MEM) begin
      if (ack) en = 4'b1111;
      else if (m_waited == TIMEOUT - 1) begin to = 1'b1; fl = 3'b111; end
      else en = 4'b0000;
    end else begin
      if (stall) en = 4'b0000;
      else if (!dd) begin en = 4'b0001; bu = 2'b01; end
    end

    exp_vec = {en, fl, bu, to};
    obs_vec = {if_en_o, id_en_o, ex_en_o, mem_en_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_flush_o, id_ex_bubble_o, ex_mem_bubble_o, dmem_timeout_o};
    checkOutput({tag, ".ctl"}, 32'(obs_vec), 32'(exp_vec));
    checkOutput({tag, ".cnt"}, stall_cycles_o, m_cnt[31:0]);

    if (!rstn) begin
      m_mode = M_RUN; m_waited = 0; m_div_pend = 1'b0; m_cnt = 0;
    end else begin
      if (m_mode == M_RUN) begin
        if (stall) begin m_mode = M_MEM; m_waited = 1; end
        else if (!br && ds && !dd) m_mode = M_DIV;
      end else if (m_mode == M_MEM) begin
        if (ack) begin m_mode = m_div_pend ? M_DIV : M_RUN; m_div_pend = 1'b0; end
        else if (m_waited == TIMEOUT - 1) begin m_mode = M_RUN; m_div_pend = 1'b0; end
        else m_waited++;
      end else begin
        if (stall) begin m_mode = M_MEM; m_waited = 1; m_div_pend = 1'b1; end
        else if (dd) m_mode = M_RUN;
      end
      if (clr) m_cnt = 0;
      else if (!en[3] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end

    @(posedge clk);
    #1;
  endtask

  // One cycle of the narrow counter instance, used to reach saturation quickly.
  task automatic smallStep(input string tag, input logic rstn, input logic inc,
                           input logic clr);
    small_rstn = rstn; small_inc = inc; small_clr = clr;
    @(posedge clk);
    #1;
    if (!rstn || clr) m_small = 0;
    else if (inc && m_small < SMALL_MAX) m_small++;
    checkOutput(tag, 32'(small_count), 32'(m_small));
  endtask

  // Idle cycle shorthand.
  task automatic idle(input string tag);
    applyStimulus(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstn_i = 0; lu_hazard_rs1_i = 0; lu_hazard_rs2_i = 0; branch_taken_i = 0;
    dmem_req_i = 0; dmem_ack_i = 0; div_start_i = 0; div_done_i = 0; stall_clr_i = 0;
    small_rstn = 0; small_inc = 0; small_clr = 0;
    @(posedge clk);
    #1;

    applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("idle0");

    applyStimulus("lu_rs2", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle("lu_after");

    applyStimulus("mem_ack0", 1, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("mem_wait", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("mem_ack", 1, 0, 0, 0, 1, 1, 0, 0, 0);
    idle("mem_after");

    for (int i = 0; i < TIMEOUT; i++) applyStimulus("mem_to", 1, 0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus("to_after", 1, 0, 0, 1, 0, 0, 0, 0, 0);

    applyStimulus("div_enter", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("div_memst", 1, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus("div_memwt", 1, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus("div_ack", 1, 0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus("div_wait", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("div_done", 1, 0, 0, 0, 0, 0, 1, 1, 0);
    idle("div_after");

    applyStimulus("br_lu", 1, 1, 0, 1, 0, 0, 0, 0, 0);

    applyStimulus("clr_stall", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("clr_after", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("memw_rst0", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("memw_rst", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("rst_after", 1, 0, 0, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      logic r_rstn, r_lu1, r_lu2, r_br, r_req, r_ack, r_ds, r_dd, r_clr;
      r_rstn = ($urandom_range(63) != 0);
      r_lu1  = ($urandom_range(3) == 0);
      r_lu2  = ($urandom_range(3) == 0);
      r_br   = ($urandom_range(7) == 0);
      r_req  = ($urandom_range(2) == 0);
      r_ack  = ($urandom_range(5) == 0);
      r_ds   = ($urandom_range(3) == 0);
      r_dd   = ($urandom_range(2) == 0);
      r_clr  = ($urandom_range(31) == 0);
      applyStimulus("rnd", r_rstn, r_lu1, r_lu2, r_br, r_req, r_ack, r_ds, r_dd, r_clr);
    end

    smallStep("sat_rst", 0, 0, 0);
    for (int i = 0; i < 10; i++) smallStep("sat_inc", 1, 1, 0);
    smallStep("sat_hold", 1, 0, 0);
    smallStep("sat_clr", 1, 1, 1);
    smallStep("sat_inc2", 1, 1, 0);
    smallStep("sat_inc3", 1, 1, 0);
    smallStep("sat_rst2", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
